// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD SPI front end
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EVAL
  } spi_rx_statetype;

  localparam int FRAME_BITS_DEFAULT = 16;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

endpackage

// File: rtl/sync_n.sv
// rtl/sync_n.sv - N-flop single-bit synchronizer with selectable reset value
module sync_n #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= {N{RESET_VAL}};
    end else begin
      stages <= {stages[N-2:0], d};
    end
  end

  assign q = stages[N-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - SPI mode-0 two-byte frame receiver with new_SPI handshake
// Optional letter/number range check: define SPI_ASCII_CHECK_EN.
module spi_frame_receiver
  import lcd_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  input  logic       ready,
  output logic [7:0] letter,
  output logic [7:0] number,
  output logic       new_SPI,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX   = 5'(FRAME_BITS + 1);
  localparam logic [3:0] WARM_DONE = 4'(SYNC_STAGES + 1);

  logic sck_s, sdi_s, cs_s;
  logic sck_d, cs_d;
  logic sck_rise, cs_fall, cs_rise;
  logic armed;
  logic [3:0] warm;

  spi_rx_statetype         state;
  logic [FRAME_BITS-1:0]   sr;
  logic [4:0]              cnt;
  logic [7:0]              sr_letter, sr_number;
  logic                    frame_ok;

  sync_n #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck), .q(sck_s)
  );
  sync_n #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi), .q(sdi_s)
  );
  sync_n #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs_n), .q(cs_s)
  );

  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // The synchronizers leave reset holding 1 on cs_n; until they have flushed,
  // a low pin would look like a falling edge, so frames already under way are ignored.
  assign armed = (warm == WARM_DONE);

  assign sr_letter = sr[FRAME_BITS-1 -: 8];
  assign sr_number = sr[FRAME_BITS-9 -: 8];

`ifdef SPI_ASCII_CHECK_EN
  logic ascii_ok;
  assign ascii_ok = (sr_letter >= ASCII_A) && (sr_letter <= ASCII_Z) &&
                    (sr_number >= ASCII_0) && (sr_number <= ASCII_9);
  assign frame_ok = (cnt == CNT_FRAME) && ascii_ok;
`else
  assign frame_ok = (cnt == CNT_FRAME);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      letter    <= 8'h00;
      number    <= 8'h00;
      new_SPI   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      warm      <= '0;
    end else begin
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (!armed) warm <= warm + 4'd1;
      if (new_SPI && ready) new_SPI <= 1'b0;

      case (state)
        IDLE: begin
          if (armed && cs_fall) begin
            state <= SHIFT;
            sr    <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            sr <= {sr[FRAME_BITS-2:0], sdi_s};
            if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
          end
          if (cs_rise) state <= EVAL;
        end
        EVAL: begin
          state <= IDLE;
          if (frame_ok) begin
            letter  <= sr_letter;
            number  <= sr_number;
            new_SPI <= 1'b1;
            // A frame taken in this same cycle is consumed, not overrun.
            overrun <= new_SPI && !ready;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
